ysyx_23060337_wbu: RTL and testbench

//  Writeback unit of the multicycle NPC. Sits between EXU/LSU and the register file.

---
 rtl/ysyx_23060337_wbu.sv | 148 ++++++++++++++
 tb/tb_ysyx_23060337_wbu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060337_wbu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060337_wbu
// Purpose : Writeback unit of the multicycle NPC. Takes one retired
//           instruction per handshake from EXU, waits for load data from the
//           LSU when needed, sign/zero-extends it, drives the register-file
//           write port and pulses a commit strobe carrying the retiring PC.
// Ports   : clk, rst_n                      clock, async active-low reset
//           in_valid / in_ready             upstream handshake
//           in_pc, in_rd, in_rd_wen,
//           in_is_load, in_ld_funct3,
//           in_addr_lo, in_result           instruction fields
//           mem_rvalid / mem_rready,
//           mem_rdata                       load-data return
//           rf_wen, rf_waddr, rf_wdata      register-file write port
//           commit_valid, commit_pc         one-cycle retire pulse
// Revision: 1.0  initial release
// ============================================================================
module ysyx_23060337_wbu #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_rd_wen,
   input  logic                  in_is_load,
   input  logic [2:0]            in_ld_funct3,
   input  logic [1:0]            in_addr_lo,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_rready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  commit_valid,
   output logic [DATA_WIDTH-1:0] commit_pc
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MEM_WAIT = 2'd1,
      S_WRITE    = 2'd2
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic                  r_rd_wen;
   logic [2:0]            r_funct3;
   logic [1:0]            r_addr_lo;
   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_rf_wen;
   logic                  r_commit_valid;

   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_ld_ext;

   // Load extraction uses the latched funct3/addr_lo so only mem_rdata is
   // sampled on the rvalid edge.
   always_comb begin
      w_byte   = 8'h00;
      w_half   = 16'h0000;
      w_ld_ext = mem_rdata;
      case (r_addr_lo)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      // Halfword lane is picked by addr_lo[1] only; misaligned bit 0 is ignored.
      w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_ld_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         3'b100:  w_ld_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         3'b001:  w_ld_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         3'b101:  w_ld_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
         default: w_ld_ext = mem_rdata;   // LW and reserved encodings
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_pc           <= '0;
         r_rd           <= '0;
         r_rd_wen       <= 1'b0;
         r_funct3       <= 3'b000;
         r_addr_lo      <= 2'b00;
         r_result       <= '0;
         r_rf_wen       <= 1'b0;
         r_commit_valid <= 1'b0;
      end else begin
         // Write/commit strobes are registered so they are high exactly
         // during the single WRITE cycle.
         r_rf_wen       <= 1'b0;
         r_commit_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_pc      <= in_pc;
                  r_rd      <= in_rd;
                  r_rd_wen  <= in_rd_wen;
                  r_funct3  <= in_ld_funct3;
                  r_addr_lo <= in_addr_lo;
                  r_result  <= in_result;
                  if (in_is_load) begin
                     r_state <= S_MEM_WAIT;
                  end else begin
                     r_state        <= S_WRITE;
                     r_rf_wen       <= in_rd_wen && (in_rd != '0);
                     r_commit_valid <= 1'b1;
                  end
               end
            end
            S_MEM_WAIT: begin
               if (mem_rvalid) begin
                  r_result       <= w_ld_ext;
                  r_state        <= S_WRITE;
                  r_rf_wen       <= r_rd_wen && (r_rd != '0);
                  r_commit_valid <= 1'b1;
               end
            end
            S_WRITE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready     = (r_state == S_IDLE);
   assign mem_rready   = (r_state == S_MEM_WAIT);
   assign rf_wen       = r_rf_wen;
   assign rf_waddr     = r_rd;
   assign rf_wdata     = r_result;
   assign commit_valid = r_commit_valid;
   assign commit_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060337_wbu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_23060337_wbu
// Purpose : Scoreboard bench for the writeback unit. A driver issues
//           directed and random instructions and pushes the expected
//           retirement into a queue; an independent monitor pops and
//           compares on every commit pulse.
// Revision: 1.0  initial release
// ============================================================================
module tb_ysyx_23060337_wbu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [4:0]  in_rd = '0;
   logic        in_rd_wen = 1'b0;
   logic        in_is_load = 1'b0;
   logic [2:0]  in_ld_funct3 = '0;
   logic [1:0]  in_addr_lo = '0;
   logic [31:0] in_result = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_rready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        commit_valid;
   logic [31:0] commit_pc;

   always #5 clk = ~clk;

   ysyx_23060337_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
      .in_is_load(in_is_load), .in_ld_funct3(in_ld_funct3),
      .in_addr_lo(in_addr_lo), .in_result(in_result),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .commit_valid(commit_valid), .commit_pc(commit_pc)
   );

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] pc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference load result computed from the RISC-V load rules.
   function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [31:0] v;
      case (f3)
         3'b000, 3'b100: begin
            v = (w >> (8 * int'(a))) & 32'h0000_00FF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
         end
         3'b001, 3'b101: begin
            v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   // Monitor: every commit pulse must match the oldest expected retirement.
   logic prev_commit = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_commit = 1'b0;
      end else begin
         if (commit_valid) begin
            if (prev_commit) check("commit_pulse_width", 64'(prev_commit), 64'd0);
            if (q.size() == 0) begin
               check("unexpected_commit", 64'(commit_valid), 64'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("rf_wen",    64'(rf_wen),    64'(e.wen));
               check("rf_waddr",  64'(rf_waddr),  64'(e.waddr));
               check("rf_wdata",  64'(rf_wdata),  64'(e.wdata));
               check("commit_pc", 64'(commit_pc), 64'(e.pc));
            end
         end else begin
            check("rf_wen_without_commit", 64'(rf_wen), 64'd0);
         end
         prev_commit = commit_valid;
      end
   end

   // All driver tasks start and end at #1 after a rising edge.
   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         mem_rvalid = 1'($urandom_range(0, 1));   // stray rvalid must be ignored
         mem_rdata  = $urandom;
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_idle", 64'(in_ready), 64'd1);
   endtask

   task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic [2:0] f3, input logic [1:0] alo,
                        input logic [31:0] res, input logic [31:0] rdata, input int dly);
      exp_t e;
      wait_idle();
      e.pc    = pc;
      e.waddr = rd;
      e.wen   = wen && (rd != 5'd0);
      e.wdata = ld ? ld_model(f3, alo, rdata) : res;
      q.push_back(e);
      in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_is_load = ld;
      in_ld_funct3 = f3; in_addr_lo = alo; in_result = res;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_pc = $urandom; in_rd = 5'($urandom); in_rd_wen = 1'($urandom);
      in_is_load = 1'($urandom); in_ld_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
      in_result = $urandom;
      if (ld) begin
         for (int i = 0; i < dly; i++) begin
            check("mem_rready_wait", 64'(mem_rready), 64'd1);
            check("no_early_commit", 64'(commit_valid), 64'd0);
            @(posedge clk); #1;
         end
         mem_rvalid = 1'b1;
         mem_rdata  = rdata;
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         check("load_latency", 64'(commit_valid), 64'd1);
      end else begin
         check("alu_latency", 64'(commit_valid), 64'd1);
      end
      check("in_ready_in_write", 64'(in_ready), 64'd0);
      check("mem_rready_in_write", 64'(mem_rready), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      check("rst_in_ready",     64'(in_ready),     64'd1);
      check("rst_mem_rready",   64'(mem_rready),   64'd0);
      check("rst_rf_wen",       64'(rf_wen),       64'd0);
      check("rst_rf_waddr",     64'(rf_waddr),     64'd0);
      check("rst_rf_wdata",     64'(rf_wdata),     64'd0);
      check("rst_commit_valid", 64'(commit_valid), 64'd0);
      check("rst_commit_pc",    64'(commit_pc),    64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      issue(32'h8000_0000, 5'd5, 1'b1, 1'b0, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0, 0);
      issue(32'h8000_0004, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h0000_1234, 32'h0, 0);
      issue(32'h8000_0008, 5'd10, 1'b1, 1'b1, 3'b000, 2'd3, 32'h0, 32'h80FF_7F01, 3);
      issue(32'h8000_000C, 5'd11, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0, 32'h8001_1234, 1);
      issue(32'h8000_0010, 5'd12, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0, 32'h8001_1234, 0);
      issue(32'h8000_0014, 5'd13, 1'b1, 1'b1, 3'b100, 2'd0, 32'h0, 32'h8001_1234, 2);
      issue(32'h8000_0018, 5'd14, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h8001_1234, 0);
      issue(32'h8000_001C, 5'd15, 1'b1, 1'b1, 3'b111, 2'd3, 32'h0, 32'hCAFE_F00D, 0);
      issue(32'h8000_0020, 5'd7, 1'b0, 1'b0, 3'b000, 2'd0, 32'h5555_AAAA, 32'h0, 0);
      idle_gap(3);

      // Reset while waiting for load data: instruction is abandoned.
      wait_idle();
      in_valid = 1'b1; in_pc = 32'h8000_0100; in_rd = 5'd9; in_rd_wen = 1'b1;
      in_is_load = 1'b1; in_ld_funct3 = 3'b010; in_addr_lo = 2'd0; in_result = 32'h1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_mem_rready", 64'(mem_rready), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready",     64'(in_ready),     64'd1);
      check("midrst_mem_rready",   64'(mem_rready),   64'd0);
      check("midrst_commit_valid", 64'(commit_valid), 64'd0);
      check("midrst_commit_pc",    64'(commit_pc),    64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      check("postrst_in_ready",     64'(in_ready),     64'd1);
      check("postrst_commit_valid", 64'(commit_valid), 64'd0);
      check("postrst_rf_wen",       64'(rf_wen),       64'd0);

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         idle_gap($urandom_range(0, 2));
         issue($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
               2'($urandom), $urandom, $urandom, $urandom_range(0, 4));
      end

      wait_idle();
      @(posedge clk); #1;
      check("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
